pattern_scan_ctrl: RTL and testbench
====================================

Name: pattern_scan_ctrl

Overview:
- Frame-level controller that configures and sequences a programmable serial pattern detector.
- The detector asserts its output when the configured pattern has occurred within the last W accepted bits.
- Per frame, the controller latches a configuration, accepts exactly frame_len bits over a valid/ready handshake, and emits a per-bit detect flag. It then reports a saturating count of detect-asserted bits and a completion pulse to the host sequencer.

Parameters:
- MAX_LEN, 8: maximum pattern length in bits.
- LEN_W, 4: width of cfg_len; must hold MAX_LEN.
- WIN_W, 5: width of cfg_win and of the hold counter.
- FRM_W, 16: width of frame_len and of the bit counter.
- CNT_W, 16: width of match_cnt.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous reset, active-high
- start  in  1  begin a frame; sampled only in IDLE
- cfg_pat  in  MAX_LEN  pattern; bit 0 = most recent bit, bit len-1 = oldest
- cfg_len  in  LEN_W  pattern length L
- cfg_win  in  WIN_W  window length W
- frame_len  in  FRM_W  number of bits in the frame, N
- bit_valid  in  1  serial bit offered
- bit_in  in  1  serial data bit
- bit_ready  out  1  controller accepts a bit; high only in RUN
- det_valid  out  1  det valid; registered, one pulse per accepted bit
- det  out  1  pattern seen within last W bits, including the current bit
- busy  out  1  high in RUN and DONE
- done  out  1  one-cycle pulse at end of frame or on config error
- cfg_err  out  1  qualifies done; held until next start
- match_cnt  out  CNT_W  count of det=1 bits in the frame; held until next start

Behaviour:
- Reset: state IDLE. bit_ready, det_valid, det, busy, done and cfg_err are 0. match_cnt is 0. History shift register, fill counter, hold counter and bit counter are cleared.
- rst asserted mid-frame: return to IDLE next edge; no done pulse; partial results discarded.
- States are IDLE, RUN, DONE.
- IDLE, start=1: latch cfg_pat/len/win and frame_len; clear history, fill, hold, bit count and match_cnt.
  - Illegal config is L=0, L>MAX_LEN, W<L or N=0. On illegal config: cfg_err<=1, done pulses the next cycle, state stays IDLE, no bits are accepted.
  - On legal config: cfg_err<=0, state goes to RUN.
- RUN: bit_ready=1 (combinational on state). An accept occurs when bit_valid and bit_ready are both high. No state advances without an accept; bubbles are allowed.
- On each accept:
  - hist <= {hist, bit_in}; fill saturates at MAX_LEN.
  - match_now = (fill+1 >= L) and the low L bits of the new history equal cfg_pat[L-1:0].
  - det <= match_now or (hold != 0); det_valid <= 1.
  - hold <= match_now ? W-L : (hold != 0 ? hold-1 : 0).
  - match_cnt increments when the new det=1, saturating at all-ones.
  - The bit counter increments. The Nth accept moves state to DONE.
- det_valid is 0 in any cycle without an accept in the previous cycle. The hold counter ticks only on accepts, not idle cycles.
- DONE: lasts one cycle. done=1, busy=1, match_cnt is final (includes bit N), bit_ready=0. The det_valid for bit N is coincident with this cycle. Next state is IDLE.
- start asserted in RUN or DONE is ignored and not queued.
- Latency: det is valid one cycle after its accept; done is valid one cycle after the Nth accept.
- Overlapping patterns are detected. For example, 10101 with pattern 101 gives two matches.

Optional Feature:
- Macro SCAN_ABORT_EN.
- Defined: adds input abort (1 bit) and output aborted (1 bit).
  - abort=1 in RUN forces DONE on the next edge. A bit accepted in the same cycle is still processed.
  - done pulses with aborted=1 and the partial match_cnt.
  - aborted is cleared on the next start. abort is ignored outside RUN.
- Undefined: the abort and aborted ports do not exist; a frame ends only after N accepts or on reset.

Decomposition:
- Package pattern_scan_pkg: state enum (IDLE, RUN, DONE), default width constants, and the cfg-legality check function.
- Sub-module pattern_window_det:
  - Contains the history shift register, fill counter, hold counter and match compare.
  - Inputs: clr, shift_en, bit_in, cfg.
  - Output: det_next.
- pattern_scan_ctrl contains the FSM, bit and match counters, and the handshake.

Test Plan:
- Pattern 101, L=3, W=4, N=13, bits 0101001101010 with bit_valid always high -> det sequence 0001100001111; match_cnt=6; done one cycle after the 13th accept.
- Same frame with bit_valid deasserted for 3 cycles after bits 4 and 9 -> identical det sequence; det_valid gaps align with the bubbles; match_cnt=6.
- Illegal configs, each with start: (L=0), (L=9, MAX_LEN=8), (L=3, W=2), (N=0) -> cfg_err=1, done pulse, bit_ready never high.
- L=2, pattern 11, W=2, N=6, bits 111111 -> det 011111 (first bit blocked by fill); match_cnt=5. CNT_W=2 with the same frame -> match_cnt saturates at 3.
- rst asserted after the 5th accept of a 13-bit frame -> IDLE; busy=0; no done. A new start completes normally. A start pulsed mid-RUN is ignored.
- SCAN_ABORT_EN: abort after the 6th accept of the first test's frame -> done with aborted=1 and match_cnt=2.

Source files
------------

// File: rtl/pattern_scan_pkg.sv
// ----------------------------------------------------------------------------
// pattern_scan_pkg
// Shared definitions for the pattern scan controller:
//   - scan_state_t : controller state encoding (IDLE, RUN, DONE)
//   - DEF_*        : default widths used as parameter defaults
//   - cfg_is_legal : frame configuration legality check
// ----------------------------------------------------------------------------
package pattern_scan_pkg;

    localparam int DEF_MAX_LEN = 8;
    localparam int DEF_LEN_W   = 4;
    localparam int DEF_WIN_W   = 5;
    localparam int DEF_FRM_W   = 16;
    localparam int DEF_CNT_W   = 16;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        DONE = 2'b10
    } scan_state_t;

    // A frame is legal when the pattern is non-empty, fits the detector,
    // fits inside the window, and the frame carries at least one bit.
    function automatic logic cfg_is_legal(input int unsigned len,
                                          input int unsigned win,
                                          input int unsigned frm,
                                          input int unsigned max_len);
        return (len != 32'd0) && (len <= max_len) && (win >= len) && (frm != 32'd0);
    endfunction

endpackage

// File: rtl/pattern_window_det.sv
// ----------------------------------------------------------------------------
// pattern_window_det
// Serial pattern detector core. Keeps the bit history, a saturating fill
// count and the hold counter that stretches a match over the rest of the
// window. det_next is the detect value for the bit currently on bit_in; the
// internal state advances only when shift_en is high.
// Ports:
//   clk, rst   : clock, synchronous active-high reset
//   clr        : synchronous clear of history, fill and hold (frame start)
//   shift_en   : accept bit_in this cycle
//   bit_in     : serial data bit
//   cfg_pat    : pattern, bit 0 = most recent bit
//   cfg_len    : pattern length L
//   cfg_win    : window length W
//   det_next   : detect value for the bit on bit_in
// ----------------------------------------------------------------------------
module pattern_window_det
    import pattern_scan_pkg::*;
#(
    parameter int MAX_LEN = DEF_MAX_LEN,
    parameter int LEN_W   = DEF_LEN_W,
    parameter int WIN_W   = DEF_WIN_W
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               clr,
    input  logic               shift_en,
    input  logic               bit_in,
    input  logic [MAX_LEN-1:0] cfg_pat,
    input  logic [LEN_W-1:0]   cfg_len,
    input  logic [WIN_W-1:0]   cfg_win,
    output logic               det_next
);

    localparam int CW = LEN_W + 1;

    logic [MAX_LEN-1:0] hist_r;
    logic [LEN_W-1:0]   fill_r;
    logic [WIN_W-1:0]   hold_r;

    logic [MAX_LEN-1:0] hist_next_s;
    logic               pat_eq_s;
    logic               fill_ok_s;
    logic               match_now_s;
    logic [WIN_W-1:0]   hold_next_s;

    // Compare the low L bits of the post-shift history against the pattern;
    // positions at or above L are don't-care.
    always_comb begin
        hist_next_s = {hist_r[MAX_LEN-2:0], bit_in};
        pat_eq_s    = 1'b1;
        for (int i = 0; i < MAX_LEN; i++) begin
            pat_eq_s = pat_eq_s &
                       ((CW'(i) >= {1'b0, cfg_len}) | (hist_next_s[i] == cfg_pat[i]));
        end
        // Until L bits have arrived the stale (cleared) history must not match.
        fill_ok_s   = ({1'b0, fill_r} + CW'(1)) >= {1'b0, cfg_len};
        match_now_s = fill_ok_s & pat_eq_s;
        det_next    = match_now_s | (hold_r != {WIN_W{1'b0}});
    end

    // A match reloads the hold so det stays high until the matched pattern
    // slides out of the W-bit window; otherwise the hold drains per accept.
    always_comb begin
        if (match_now_s) begin
            hold_next_s = cfg_win - WIN_W'(cfg_len);
        end else if (hold_r != {WIN_W{1'b0}}) begin
            hold_next_s = hold_r - WIN_W'(1);
        end else begin
            hold_next_s = {WIN_W{1'b0}};
        end
    end

    // History, fill and hold state; advances only on accepted bits.
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            hist_r <= {MAX_LEN{1'b0}};
            fill_r <= {LEN_W{1'b0}};
            hold_r <= {WIN_W{1'b0}};
        end else if (shift_en) begin
            hist_r <= hist_next_s;
            fill_r <= (fill_r < LEN_W'(MAX_LEN)) ? fill_r + LEN_W'(1) : fill_r;
            hold_r <= hold_next_s;
        end
    end

endmodule

// File: rtl/pattern_scan_ctrl.sv
// ----------------------------------------------------------------------------
// pattern_scan_ctrl
// Frame controller for the serial pattern detector. On start in IDLE it
// latches the configuration, rejects illegal setups with cfg_err + done,
// otherwise accepts exactly frame_len bits over bit_valid/bit_ready, emits a
// registered det/det_valid per accepted bit, and finishes with a one-cycle
// DONE state carrying the done pulse and the final saturating match_cnt.
// Optional build macro SCAN_ABORT_EN adds abort (in) / aborted (out): abort
// in RUN ends the frame early with aborted=1 and the partial count.
// Ports:
//   clk, rst                  : clock, synchronous active-high reset
//   start                     : begin a frame (sampled only in IDLE)
//   cfg_pat/cfg_len/cfg_win   : pattern, pattern length, window length
//   frame_len                 : bits per frame
//   bit_valid, bit_in         : serial bit offer
//   bit_ready                 : high while in RUN
//   det_valid, det            : per-accepted-bit detect flag (1 cycle later)
//   busy                      : high in RUN and DONE
//   done, cfg_err             : end-of-frame pulse and its error qualifier
//   match_cnt                 : saturating count of det=1 bits
// ----------------------------------------------------------------------------
module pattern_scan_ctrl
    import pattern_scan_pkg::*;
#(
    parameter int MAX_LEN = DEF_MAX_LEN,
    parameter int LEN_W   = DEF_LEN_W,
    parameter int WIN_W   = DEF_WIN_W,
    parameter int FRM_W   = DEF_FRM_W,
    parameter int CNT_W   = DEF_CNT_W
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [MAX_LEN-1:0] cfg_pat,
    input  logic [LEN_W-1:0]   cfg_len,
    input  logic [WIN_W-1:0]   cfg_win,
    input  logic [FRM_W-1:0]   frame_len,
    input  logic               bit_valid,
    input  logic               bit_in,
`ifdef SCAN_ABORT_EN
    input  logic               abort,
    output logic               aborted,
`endif
    output logic               bit_ready,
    output logic               det_valid,
    output logic               det,
    output logic               busy,
    output logic               done,
    output logic               cfg_err,
    output logic [CNT_W-1:0]   match_cnt
);

    scan_state_t        state_r;
    logic [MAX_LEN-1:0] pat_r;
    logic [LEN_W-1:0]   len_r;
    logic [WIN_W-1:0]   win_r;
    logic [FRM_W-1:0]   frm_r;
    logic [FRM_W-1:0]   bit_cnt_r;

    logic accept_s;
    logic start_ok_s;
    logic legal_s;
    logic last_bit_s;
    logic det_next_s;
    logic abort_s;

`ifdef SCAN_ABORT_EN
    assign abort_s = abort;
`else
    assign abort_s = 1'b0;
`endif

    assign bit_ready  = (state_r == RUN);
    assign accept_s   = bit_valid & bit_ready;
    assign start_ok_s = start & (state_r == IDLE);
    assign last_bit_s = (bit_cnt_r + FRM_W'(1)) == frm_r;
    assign legal_s    = cfg_is_legal(32'(cfg_len), 32'(cfg_win), 32'(frame_len), MAX_LEN);

    pattern_window_det #(
        .MAX_LEN (MAX_LEN),
        .LEN_W   (LEN_W),
        .WIN_W   (WIN_W)
    ) u_win (
        .clk      (clk),
        .rst      (rst),
        .clr      (start_ok_s),
        .shift_en (accept_s),
        .bit_in   (bit_in),
        .cfg_pat  (pat_r),
        .cfg_len  (len_r),
        .cfg_win  (win_r),
        .det_next (det_next_s)
    );

    // Frame FSM with registered handshake results, counters and status.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r   <= IDLE;
            pat_r     <= {MAX_LEN{1'b0}};
            len_r     <= {LEN_W{1'b0}};
            win_r     <= {WIN_W{1'b0}};
            frm_r     <= {FRM_W{1'b0}};
            bit_cnt_r <= {FRM_W{1'b0}};
            det_valid <= 1'b0;
            det       <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            cfg_err   <= 1'b0;
            match_cnt <= {CNT_W{1'b0}};
`ifdef SCAN_ABORT_EN
            aborted   <= 1'b0;
`endif
        end else begin
            det_valid <= accept_s;
            det       <= accept_s & det_next_s;
            // Accepts only happen in RUN, so these never race the IDLE clears.
            if (accept_s) begin
                bit_cnt_r <= bit_cnt_r + FRM_W'(1);
                if (det_next_s && (match_cnt != {CNT_W{1'b1}})) begin
                    match_cnt <= match_cnt + CNT_W'(1);
                end
            end

            case (state_r)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        pat_r     <= cfg_pat;
                        len_r     <= cfg_len;
                        win_r     <= cfg_win;
                        frm_r     <= frame_len;
                        bit_cnt_r <= {FRM_W{1'b0}};
                        match_cnt <= {CNT_W{1'b0}};
`ifdef SCAN_ABORT_EN
                        aborted   <= 1'b0;
`endif
                        if (legal_s) begin
                            state_r <= RUN;
                            busy    <= 1'b1;
                            cfg_err <= 1'b0;
                        end else begin
                            // Rejected frame: report immediately, never enter RUN.
                            state_r <= IDLE;
                            busy    <= 1'b0;
                            cfg_err <= 1'b1;
                            done    <= 1'b1;
                        end
                    end
                end
                RUN: begin
                    if ((accept_s && last_bit_s) || abort_s) begin
                        state_r <= DONE;
                        done    <= 1'b1;
`ifdef SCAN_ABORT_EN
                        aborted <= abort_s;
`endif
                    end
                end
                DONE: begin
                    state_r <= IDLE;
                    done    <= 1'b0;
                    busy    <= 1'b0;
                end
                default: begin
                    state_r <= IDLE;
                    done    <= 1'b0;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pattern_scan_ctrl.sv
// ----------------------------------------------------------------------------
// tb_pattern_scan_ctrl
// Directed bench for pattern_scan_ctrl. A window-based reference (a pattern
// occurrence lying entirely inside the last W bits) produces the expected
// det per bit; the driver turns that into per-cycle expected outputs, which
// a negedge compare process checks against two DUTs (CNT_W=16 and CNT_W=2).
// Literal expectations from hand calculation pin the reference itself.
// ----------------------------------------------------------------------------
module tb_pattern_scan_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, start, bit_valid, bit_in;
    logic [7:0]  cfg_pat;
    logic [3:0]  cfg_len;
    logic [4:0]  cfg_win;
    logic [15:0] frame_len;

    logic        bit_ready, det_valid, det, busy, done, cfg_err;
    logic [15:0] match_cnt;
    logic        bit_ready2, det_valid2, det2, busy2, done2, cfg_err2;
    logic [1:0]  match_cnt2;
`ifdef SCAN_ABORT_EN
    logic        abort, aborted, aborted2;
`endif

    pattern_scan_ctrl dut (
        .clk(clk), .rst(rst), .start(start), .cfg_pat(cfg_pat), .cfg_len(cfg_len),
        .cfg_win(cfg_win), .frame_len(frame_len), .bit_valid(bit_valid), .bit_in(bit_in),
`ifdef SCAN_ABORT_EN
        .abort(abort), .aborted(aborted),
`endif
        .bit_ready(bit_ready), .det_valid(det_valid), .det(det), .busy(busy),
        .done(done), .cfg_err(cfg_err), .match_cnt(match_cnt)
    );

    pattern_scan_ctrl #(.CNT_W(2)) dut2 (
        .clk(clk), .rst(rst), .start(start), .cfg_pat(cfg_pat), .cfg_len(cfg_len),
        .cfg_win(cfg_win), .frame_len(frame_len), .bit_valid(bit_valid), .bit_in(bit_in),
`ifdef SCAN_ABORT_EN
        .abort(abort), .aborted(aborted2),
`endif
        .bit_ready(bit_ready2), .det_valid(det_valid2), .det(det2), .busy(busy2),
        .done(done2), .cfg_err(cfg_err2), .match_cnt(match_cnt2)
    );

    int n_chk  = 0;
    int n_fail = 0;

    // Expected outputs for the current cycle.
    logic chk = 1'b0;
    logic e_ready, e_dv, e_det, e_busy, e_done, e_err, e_abt;
    int   e_sum;
    logic [63:0] got_seq;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int sat(input int v, input int maxv);
        return (v > maxv) ? maxv : v;
    endfunction

    // det for bit k (1-based) of an n-bit frame: some full occurrence of the
    // pattern ends at j <= k and starts no earlier than k-W+1.
    function automatic logic win_det(input logic [63:0] seq, input int n, input int k,
                                     input logic [7:0] pat, input int len, input int win);
        logic hit;
        logic eq;
        hit = 1'b0;
        for (int j = len; j <= k; j++) begin
            if (j - len + 1 >= k - win + 1) begin
                eq = 1'b1;
                for (int i = 0; i < len; i++) begin
                    if (seq[n - (j - i)] != pat[i]) eq = 1'b0;
                end
                if (eq) hit = 1'b1;
            end
        end
        return hit;
    endfunction

    // Per-cycle comparison of both DUTs against the expectations.
    always @(negedge clk) begin
        if (chk) begin
            check("bit_ready", 32'(bit_ready), 32'(e_ready));
            check("busy", 32'(busy), 32'(e_busy));
            check("done", 32'(done), 32'(e_done));
            check("cfg_err", 32'(cfg_err), 32'(e_err));
            check("det_valid", 32'(det_valid), 32'(e_dv));
            if (e_dv) check("det", 32'(det), 32'(e_det));
            check("match_cnt", 32'(match_cnt), 32'(sat(e_sum, 65535)));
            check("bit_ready_w2", 32'(bit_ready2), 32'(e_ready));
            check("busy_w2", 32'(busy2), 32'(e_busy));
            check("done_w2", 32'(done2), 32'(e_done));
            check("cfg_err_w2", 32'(cfg_err2), 32'(e_err));
            check("det_valid_w2", 32'(det_valid2), 32'(e_dv));
            if (e_dv) check("det_w2", 32'(det2), 32'(e_det));
            check("match_cnt_w2", 32'(match_cnt2), 32'(sat(e_sum, 3)));
`ifdef SCAN_ABORT_EN
            check("aborted", 32'(aborted), 32'(e_abt));
            check("aborted_w2", 32'(aborted2), 32'(e_abt));
`endif
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Run one frame. seq holds the bits in written order (first bit is MSB of
    // the n used bits). gapm[k]=1 inserts 3 idle cycles after accept k.
    // rst_at/abort_at/mstart_at (0 = unused) inject reset after accept
    // rst_at, abort with accept abort_at, or a stray start with accept mstart_at+1.
    task automatic run_frame(input logic [7:0] pat, input int len, input int win, input int n,
                             input logic [63:0] seq, input logic [63:0] gapm,
                             input int rst_at, input int abort_at, input int mstart_at);
        logic legal, fin, ab_now, offered;
        int   k, gaps;
        legal = (len != 0) && (len <= 8) && (win >= len) && (n != 0);
        got_seq   = 64'd0;
        cfg_pat   = pat;
        cfg_len   = 4'(len);
        cfg_win   = 5'(win);
        frame_len = 16'(n);
        start     = 1'b1;
        bit_valid = 1'b0;
        tick();
        start = 1'b0;
        e_sum = 0; e_dv = 1'b0; e_abt = 1'b0;
        if (!legal) begin
            e_err = 1'b1; e_done = 1'b1; e_ready = 1'b0; e_busy = 1'b0;
            tick();
            e_done = 1'b0;
            tick();
            return;
        end
        e_err = 1'b0; e_ready = 1'b1; e_busy = 1'b1; e_done = 1'b0;
        k = 0; gaps = 0; fin = 1'b0;
        while (!fin) begin
            ab_now = 1'b0;
            if (rst_at != 0 && k == rst_at) begin
                rst = 1'b1; bit_valid = 1'b1; bit_in = 1'b1;
                tick();
                rst = 1'b0; bit_valid = 1'b0;
                e_ready = 1'b0; e_busy = 1'b0; e_done = 1'b0; e_err = 1'b0;
                e_dv = 1'b0; e_sum = 0; e_abt = 1'b0;
                tick();
                return;
            end
            if (gaps > 0) begin
                bit_valid = 1'b0;
                gaps--;
            end else begin
                bit_valid = 1'b1;
                bit_in    = seq[n - k - 1];
            end
            start = (mstart_at != 0) && (k == mstart_at);
`ifdef SCAN_ABORT_EN
            if (abort_at != 0 && k + 1 == abort_at && bit_valid) ab_now = 1'b1;
            abort = ab_now;
`endif
            offered = bit_valid;
            tick();
            start = 1'b0; bit_valid = 1'b0;
`ifdef SCAN_ABORT_EN
            abort = 1'b0;
`endif
            if (offered) begin
                k++;
                got_seq = {got_seq[62:0], det};
                e_dv  = 1'b1;
                e_det = win_det(seq, n, k, pat, len, win);
                e_sum = e_sum + int'(e_det);
                if (gapm[k]) gaps = 3;
            end else begin
                e_dv = 1'b0;
            end
            if ((offered && k == n) || ab_now) begin
                e_ready = 1'b0; e_done = 1'b1; e_abt = ab_now; fin = 1'b1;
            end
        end
        tick();
        e_dv = 1'b0; e_done = 1'b0; e_busy = 1'b0;
        tick();
    endtask

    localparam logic [63:0] SEQ1 = 64'b0101001101010;

    initial begin
        rst = 1'b1; start = 1'b0; bit_valid = 1'b0; bit_in = 1'b0;
        cfg_pat = 8'd0; cfg_len = 4'd0; cfg_win = 5'd0; frame_len = 16'd0;
`ifdef SCAN_ABORT_EN
        abort = 1'b0;
`endif
        e_ready = 1'b0; e_dv = 1'b0; e_det = 1'b0; e_busy = 1'b0;
        e_done = 1'b0; e_err = 1'b0; e_abt = 1'b0; e_sum = 0;
        got_seq = 64'd0;
        tick();
        chk = 1'b1;          // reset state
        tick();
        rst = 1'b0;
        tick();

        // Basic frame, pattern 101, continuous valid.
        run_frame(8'b101, 3, 4, 13, SEQ1, 64'd0, 0, 0, 0);
        check("t1_det_seq", 32'(got_seq[12:0]), 32'(13'b0001100001111));
        check("t1_cnt", 32'(match_cnt), 32'd6);

        // Same frame with 3-cycle bubbles after bits 4 and 9.
        run_frame(8'b101, 3, 4, 13, SEQ1, 64'h210, 0, 0, 0);
        check("t2_det_seq", 32'(got_seq[12:0]), 32'(13'b0001100001111));
        check("t2_cnt", 32'(match_cnt), 32'd6);

        // Illegal configurations.
        run_frame(8'b101, 0, 4, 5, SEQ1, 64'd0, 0, 0, 0);
        check("ill_len0_err", 32'(cfg_err), 32'd1);
        run_frame(8'b101, 9, 10, 5, SEQ1, 64'd0, 0, 0, 0);
        check("ill_len9_err", 32'(cfg_err), 32'd1);
        run_frame(8'b101, 3, 2, 5, SEQ1, 64'd0, 0, 0, 0);
        check("ill_win_err", 32'(cfg_err), 32'd1);
        run_frame(8'b101, 3, 4, 0, SEQ1, 64'd0, 0, 0, 0);
        check("ill_n0_err", 32'(cfg_err), 32'd1);

        // Fill blocking and count saturation.
        run_frame(8'b11, 2, 2, 6, 64'b111111, 64'd0, 0, 0, 0);
        check("t4_det_seq", 32'(got_seq[5:0]), 32'(6'b011111));
        check("t4_cnt", 32'(match_cnt), 32'd5);
        check("t4_cnt_w2_sat", 32'(match_cnt2), 32'd3);
        check("t4_err_clr", 32'(cfg_err), 32'd0);

        // Reset mid-frame, then a full frame with a stray start during RUN.
        run_frame(8'b101, 3, 4, 13, SEQ1, 64'd0, 5, 0, 0);
        check("rst_busy", 32'(busy), 32'd0);
        run_frame(8'b101, 3, 4, 13, SEQ1, 64'd0, 0, 0, 3);
        check("t5_det_seq", 32'(got_seq[12:0]), 32'(13'b0001100001111));
        check("t5_cnt", 32'(match_cnt), 32'd6);

`ifdef SCAN_ABORT_EN
        // Abort together with the 6th accept.
        run_frame(8'b101, 3, 4, 13, SEQ1, 64'd0, 0, 6, 0);
        check("abort_cnt", 32'(match_cnt), 32'd2);
        check("abort_flag", 32'(aborted), 32'd1);
`endif

        chk = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
